// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel-in / window-out handshake bundle for sobel_window_gen
interface sobel_window_gen_if #(
  parameter int DATA_W = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [9*DATA_W-1:0]   m_window;
  logic                  m_last;
  logic                  frame_done;

  // window generator side: consumes pixels, produces windows
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_window, m_last, frame_done
  );

  // upstream/downstream side: supplies pixels, consumes windows
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_window, m_last, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 neighbourhood builder with two line buffers for a SIZE x SIZE frame
module sobel_window_gen #(
  parameter int SIZE   = 100,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sobel_window_gen_if.slave bus
);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [0:0]            state;

  // lb0 holds the previous row, lb1 the row before that
  logic [DATA_W-1:0]     lb0 [SIZE];
  logic [DATA_W-1:0]     lb1 [SIZE];

  // two most recent columns; index 0 = oldest row, 2 = current row
  logic [DATA_W-1:0]     col_a   [3];
  logic [DATA_W-1:0]     col_b   [3];
  logic [DATA_W-1:0]     new_col [3];
  logic [9*DATA_W-1:0]   next_window;

  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  frame_done_q;
  logic [9*DATA_W-1:0]   m_window_q;

  logic                  s_ready;
  logic                  accept;
  logic                  col_end;
  logic                  row_end;
  logic                  frame_end;
  logic                  produce;

  assign s_ready   = !m_valid_q || bus.m_ready;
  assign accept    = bus.s_valid && s_ready;
  assign col_end   = (col == LAST_IDX);
  assign row_end   = (row == LAST_IDX);
  assign frame_end = accept && col_end && row_end;
  // columns 0/1 would combine stale columns from the previous row, so they never emit
  assign produce   = accept && (state == ST_STREAM) && (col >= TWO);

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_window   = m_window_q;
  assign bus.m_last     = m_last_q;
  assign bus.frame_done = frame_done_q;

  // assemble the incoming column and the window it would complete
  always_comb begin
    new_col[0] = lb1[col];
    new_col[1] = lb0[col];
    new_col[2] = bus.s_data;
    next_window = '0;
    for (int i = 0; i < 3; i++) begin
      next_window[(3*i + 0)*DATA_W +: DATA_W] = col_a[i];
      next_window[(3*i + 1)*DATA_W +: DATA_W] = col_b[i];
      next_window[(3*i + 2)*DATA_W +: DATA_W] = new_col[i];
    end
  end

  // raster position counters and fill/stream phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row   <= '0;
      col   <= '0;
      state <= ST_FILL;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
      if (state == ST_FILL && row == ONE && col_end) begin
        state <= ST_STREAM;
      end else if (state == ST_STREAM && row_end && col_end) begin
        state <= ST_FILL;
      end
    end
  end

  // line buffers cascade one row down and column regs shift left on every accept
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.s_data;
      for (int i = 0; i < 3; i++) begin
        col_a[i] <= col_b[i];
        col_b[i] <= new_col[i];
      end
    end
  end

  // output window register: load on a producing accept, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_window_q   <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (produce) begin
        m_valid_q  <= 1'b1;
        m_window_q <= next_window;
        m_last_q   <= frame_end;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - randomized self-checking bench for sobel_window_gen
module tb_sobel_window_gen;
  logic clk;
  logic rst_n;
  int   sel;
  logic drv_valid;
  logic [7:0] drv_data;
  logic mon_ready;

  logic        mon_s_ready;
  logic        mon_m_valid;
  logic [71:0] mon_m_window;
  logic        mon_m_last;
  logic        mon_frame_done;

  int checks;
  int failures;

  logic [7:0] pix [10000];

  sobel_window_gen_if #(.DATA_W(8)) if5 ();
  sobel_window_gen_if #(.DATA_W(8)) if100 ();
  sobel_window_gen_if #(.DATA_W(8)) if3 ();

  sobel_window_gen #(.SIZE(5),   .DATA_W(8)) dut5   (.clk(clk), .rst_n(rst_n), .bus(if5));
  sobel_window_gen #(.SIZE(100), .DATA_W(8)) dut100 (.clk(clk), .rst_n(rst_n), .bus(if100));
  sobel_window_gen #(.SIZE(3),   .DATA_W(8)) dut3   (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if5.s_valid   = (sel == 0) && drv_valid;
  assign if100.s_valid = (sel == 1) && drv_valid;
  assign if3.s_valid   = (sel == 2) && drv_valid;
  assign if5.s_data    = drv_data;
  assign if100.s_data  = drv_data;
  assign if3.s_data    = drv_data;
  assign if5.m_ready   = (sel == 0) && mon_ready;
  assign if100.m_ready = (sel == 1) && mon_ready;
  assign if3.m_ready   = (sel == 2) && mon_ready;

  assign mon_s_ready    = (sel == 0) ? if5.s_ready    : (sel == 1) ? if100.s_ready    : if3.s_ready;
  assign mon_m_valid    = (sel == 0) ? if5.m_valid    : (sel == 1) ? if100.m_valid    : if3.m_valid;
  assign mon_m_window   = (sel == 0) ? if5.m_window   : (sel == 1) ? if100.m_window   : if3.m_window;
  assign mon_m_last     = (sel == 0) ? if5.m_last     : (sel == 1) ? if100.m_last     : if3.m_last;
  assign mon_frame_done = (sel == 0) ? if5.frame_done : (sel == 1) ? if100.frame_done : if3.frame_done;

  always #5 clk = ~clk;

  // pixel (r,c) of frame f: base image plus frame number, wrapping at 256
  function automatic logic [7:0] pval(input int f, input int r, input int c, input int size);
    return pix[r*size + c] + 8'(f);
  endfunction

  // window centred on (r-1,c-1): row i=0 is the oldest, col j=0 leftmost
  function automatic logic [71:0] exp_win(input int f, input int r, input int c, input int size);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i + j)*8 +: 8] = pval(f, r - 2 + i, c - 2 + j, size);
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drv_valid = 1'b0;
    mon_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (mon_m_valid !== 1'b0 || mon_m_last !== 1'b0 || mon_frame_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags dut=%0d got valid=%b last=%b done=%b want 0 0 0",
                 s, mon_m_valid, mon_m_last, mon_frame_done);
      end
      checks++;
      if (mon_m_window !== 72'h0) begin
        failures++;
        $display("FAIL reset_window dut=%0d got %h want 0", s, mon_m_window);
      end
      checks++;
      if (mon_s_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_s_ready dut=%0d got %b want 1", s, mon_s_ready);
      end
    end
    sel = 0;
    @(negedge clk);
  endtask

  // stream nframes frames through the selected DUT and score every cycle against the model
  task automatic run_frames(input int size, input int nframes, input int vpct, input int rpct,
                            input string name);
    int total_p, total_w, m, n, k, cyc, fd_cnt, budget;
    int f, r, c, q;
    logic exp_valid, fd_exp, held, held_last, acc, prod, pv, pr, plast, exp_last;
    logic [71:0] held_win, pwin, ew;
    total_p = nframes * size * size;
    m = (size - 2) * (size - 2);
    total_w = nframes * m;
    budget = total_p * 10 + 200;
    n = 0; k = 0; cyc = 0; fd_cnt = 0;
    exp_valid = 1'b0; fd_exp = 1'b0; held = 1'b0; held_last = 1'b0; held_win = '0;
    while ((n < total_p || k < total_w) && cyc < budget) begin
      drv_valid = (n < total_p) && (int'($urandom_range(99)) < vpct);
      f = n / (size * size);
      r = (n % (size * size)) / size;
      c = n % size;
      drv_data = (n < total_p) ? pval(f, r, c, size) : 8'h00;
      mon_ready = (int'($urandom_range(99)) < rpct);
      #1;
      checks++;
      if (mon_m_valid !== exp_valid) begin
        failures++;
        $display("FAIL %s m_valid cyc=%0d got %b want %b", name, cyc, mon_m_valid, exp_valid);
      end
      checks++;
      if (mon_frame_done !== fd_exp) begin
        failures++;
        $display("FAIL %s frame_done cyc=%0d got %b want %b", name, cyc, mon_frame_done, fd_exp);
      end
      checks++;
      if (mon_s_ready !== (!exp_valid || mon_ready)) begin
        failures++;
        $display("FAIL %s s_ready cyc=%0d got %b want %b", name, cyc, mon_s_ready,
                 (!exp_valid || mon_ready));
      end
      if (held) begin
        checks++;
        if (mon_m_window !== held_win || mon_m_last !== held_last) begin
          failures++;
          $display("FAIL %s stall_hold cyc=%0d got %h/%b want %h/%b", name, cyc,
                   mon_m_window, mon_m_last, held_win, held_last);
        end
      end
      if (mon_frame_done === 1'b1) fd_cnt++;
      if (mon_m_valid === 1'b1 && mon_ready) begin
        checks++;
        if (k >= total_w) begin
          failures++;
          $display("FAIL %s extra_window cyc=%0d got %h want none", name, cyc, mon_m_window);
        end else begin
          f = k / m;
          q = k % m;
          r = 2 + q / (size - 2);
          c = 2 + q % (size - 2);
          ew = exp_win(f, r, c, size);
          exp_last = (r == size - 1) && (c == size - 1);
          if (mon_m_window !== ew || mon_m_last !== exp_last) begin
            failures++;
            $display("FAIL %s window%0d got %h last=%b want %h last=%b", name, k,
                     mon_m_window, mon_m_last, ew, exp_last);
          end
        end
        k++;
      end
      acc = drv_valid && mon_s_ready;
      pv = mon_m_valid; pr = mon_ready; pwin = mon_m_window; plast = mon_m_last;
      @(posedge clk);
      held = pv && !pr;
      held_win = pwin;
      held_last = plast;
      prod = 1'b0;
      fd_exp = 1'b0;
      if (acc) begin
        r = (n % (size * size)) / size;
        c = n % size;
        prod = (r >= 2) && (c >= 2);
        fd_exp = (r == size - 1) && (c == size - 1);
        n++;
      end
      exp_valid = prod || held;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (n != total_p || k != total_w) begin
      failures++;
      $display("FAIL %s timeout pixels=%0d windows=%0d want %0d/%0d", name, n, k, total_p, total_w);
    end
    drv_valid = 1'b0;
    mon_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mon_m_valid !== exp_valid || mon_frame_done !== fd_exp) begin
        failures++;
        $display("FAIL %s drain%0d got valid=%b done=%b want %b %b", name, i,
                 mon_m_valid, mon_frame_done, exp_valid, fd_exp);
      end
      if (mon_frame_done === 1'b1) fd_cnt++;
      @(posedge clk);
      exp_valid = 1'b0;
      fd_exp = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (fd_cnt != nframes) begin
      failures++;
      $display("FAIL %s frame_done_count got %0d want %0d", name, fd_cnt, nframes);
    end
  endtask

  task automatic test_basic();
    sel = 0;
    run_frames(5, 1, 100, 100, "basic5");
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_frames(5, 1, 100, 50, "backpressure5");
  endtask

  task automatic test_bubbles();
    sel = 0;
    run_frames(5, 1, 50, 100, "bubbles5");
  endtask

  task automatic test_mid_reset();
    int accepted, cyc;
    sel = 0;
    accepted = 0;
    cyc = 0;
    drv_valid = 1'b1;
    mon_ready = 1'b1;
    while (accepted < 13 && cyc < 100) begin
      drv_data = pix[accepted];
      #1;
      if (mon_s_ready === 1'b1) accepted++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    drv_valid = 1'b0;
    #1;
    checks++;
    if (accepted != 13 || mon_m_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_prefill got accepted=%0d valid=%b want 13 1", accepted, mon_m_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mon_m_valid !== 1'b0 || mon_m_last !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flush got valid=%b last=%b want 0 0", mon_m_valid, mon_m_last);
    end
    @(negedge clk);
    run_frames(5, 1, 100, 100, "after_reset5");
  endtask

  task automatic test_back_to_back();
    sel = 0;
    run_frames(5, 3, 70, 60, "b2b_random5");
    for (int i = 0; i < 10000; i++) pix[i] = 8'($urandom);
    sel = 1;
    run_frames(100, 2, 100, 100, "b2b_size100");
    for (int i = 0; i < 10000; i++) pix[i] = 8'(i);
  endtask

  task automatic test_min_size();
    sel = 2;
    run_frames(3, 1, 100, 100, "min3");
    sel = 2;
    run_frames(3, 2, 60, 60, "min3_random");
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    sel = 0;
    drv_valid = 1'b0;
    drv_data = 8'h00;
    mon_ready = 1'b1;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 10000; i++) pix[i] = 8'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_back_to_back();
    test_min_size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
